// File: rtl/beep_pkg.sv
// Shared definitions for the buzzer scale sequencer: FSM states, note table
// defaults and the volume-to-duty shift mapping.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int NOTE_NUM = 7;

  // Tone periods in clocks at 50 MHz for DO..XI.
  localparam logic [17:0] DEF_DO = 18'd190_840;
  localparam logic [17:0] DEF_RE = 18'd170_068;
  localparam logic [17:0] DEF_MI = 18'd151_515;
  localparam logic [17:0] DEF_FA = 18'd143_266;
  localparam logic [17:0] DEF_SO = 18'd127_551;
  localparam logic [17:0] DEF_LA = 18'd113_636;
  localparam logic [17:0] DEF_XI = 18'd101_214;

  // vol 3 -> period/2, vol 0 -> period/16.
  function automatic logic [2:0] vol_shift(input logic [1:0] v);
    return 3'd4 - {1'b0, v};
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave generator: free-running period counter with a registered
// comparator output; restart realigns the waveform to the slot start.
module beep_tone_gen #(
  parameter int FREQ_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] period,
  input  logic [FREQ_W-1:0] duty,
  input  logic              en,
  input  logic              restart,
  output logic              wave
);

  logic [FREQ_W-1:0] freq_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_cnt <= '0;
      wave     <= 1'b0;
    end else begin
      wave <= en && (freq_cnt < duty);
      if (restart || (freq_cnt >= period - 1'b1))
        freq_cnt <= '0;
      else
        freq_cnt <= freq_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_seq.sv
// Buzzer scale sequencer: plays DO..XI once or looped, with a silent gap at
// the end of each note slot and a 4-level duty-cycle volume.
module beep_seq
  import beep_pkg::*;
#(
  parameter int                CNT_W     = 25,
  parameter logic [CNT_W-1:0]  TIME_NOTE = 25'd24_999_999,
  parameter logic [CNT_W-1:0]  TIME_GAP  = 25'd2_499_999,
  parameter int                FREQ_W    = 18,
  parameter logic [FREQ_W-1:0] DO        = DEF_DO,
  parameter logic [FREQ_W-1:0] RE        = DEF_RE,
  parameter logic [FREQ_W-1:0] MI        = DEF_MI,
  parameter logic [FREQ_W-1:0] FA        = DEF_FA,
  parameter logic [FREQ_W-1:0] SO        = DEF_SO,
  parameter logic [FREQ_W-1:0] LA        = DEF_LA,
  parameter logic [FREQ_W-1:0] XI        = DEF_XI
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic [1:0] vol,
  output logic       beep,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic       done
);

  localparam logic [CNT_W-1:0] SLOT_END  = TIME_NOTE - 1'b1;
  localparam logic [CNT_W-1:0] TONE_END  = TIME_NOTE - TIME_GAP;
  localparam logic [2:0]       LAST_NOTE = 3'(NOTE_NUM - 1);

  state_t            state;
  logic [CNT_W-1:0]  slot_cnt, slot_nxt;
  logic              loop_r;
  logic [FREQ_W-1:0] duty_r, period, next_period;
  logic [2:0]        next_idx;
  logic              accept, slot_end, restart, en;

  function automatic logic [FREQ_W-1:0] period_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return DO;
      3'd1:    return RE;
      3'd2:    return MI;
      3'd3:    return FA;
      3'd4:    return SO;
      3'd5:    return LA;
      3'd6:    return XI;
      default: return DO;
    endcase
  endfunction

  always_comb begin
    accept      = (state == ST_IDLE) && start && !stop;
    slot_end    = (state != ST_IDLE) && (slot_cnt == SLOT_END);
    slot_nxt    = slot_cnt + 1'b1;
    next_idx    = (note_idx == LAST_NOTE) ? 3'd0 : note_idx + 3'd1;
    period      = period_of(note_idx);
    // Duty for the slot about to begin is computed from that slot's note.
    next_period = accept ? period_of(3'd0) : period_of(next_idx);
    restart     = accept || slot_end;
    en          = (state == ST_TONE) && !stop;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      slot_cnt <= '0;
      note_idx <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loop_r   <= 1'b0;
      duty_r   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state    <= ST_TONE;
        slot_cnt <= '0;
        note_idx <= 3'd0;
        busy     <= 1'b1;
        loop_r   <= loop;
        duty_r   <= next_period >> vol_shift(vol);
      end else if (state != ST_IDLE) begin
        if (stop) begin
          state    <= ST_IDLE;
          slot_cnt <= '0;
          note_idx <= 3'd0;
          busy     <= 1'b0;
        end else if (slot_end) begin
          slot_cnt <= '0;
          if ((note_idx == LAST_NOTE) && !loop_r) begin
            state    <= ST_IDLE;
            note_idx <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            state    <= ST_TONE;
            note_idx <= next_idx;
            duty_r   <= next_period >> vol_shift(vol);
          end
        end else begin
          slot_cnt <= slot_nxt;
          state    <= (slot_nxt < TONE_END) ? ST_TONE : ST_GAP;
        end
      end
    end
  end

  beep_tone_gen #(.FREQ_W(FREQ_W)) u_tone (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .period  (period),
    .duty    (duty_r),
    .en      (en),
    .restart (restart),
    .wave    (beep)
  );

endmodule

// File: tb/tb_beep_seq.sv
// Self-checking bench for beep_seq with shortened timing; compares every
// cycle against a time-since-start reference model plus directed vectors.
module tb_beep_seq;

  localparam int NOTE = 600;
  localparam int GAP  = 100;
  localparam int LEN  = 7 * NOTE;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0] vol = 2'd3;
  logic       beep, busy, done;
  logic [2:0] note_idx;

  always #5 sys_clk = ~sys_clk;

  beep_seq #(
    .CNT_W(25), .TIME_NOTE(25'd600), .TIME_GAP(25'd100), .FREQ_W(18),
    .DO(18'd150), .RE(18'd100), .MI(18'd50), .FA(18'd25),
    .SO(18'd15), .LA(18'd10), .XI(18'd5)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .loop(loop), .vol(vol), .beep(beep), .busy(busy),
    .note_idx(note_idx), .done(done)
  );

  // Reference model: position in the sequence is simply clocks since start.
  bit         m_active = 1'b0, m_loop = 1'b0, m_beep = 1'b0, m_done = 1'b0;
  int         m_t = 0;
  logic [1:0] m_svol = 2'd0;

  function automatic int per_of(input int n);
    case (n)
      0: return 150;
      1: return 100;
      2: return 50;
      3: return 25;
      4: return 15;
      5: return 10;
      default: return 5;
    endcase
  endfunction

  function automatic bit tone_on(input int t, input logic [1:0] v);
    int p, per;
    p   = t % NOTE;
    per = per_of(t / NOTE);
    return (p < NOTE - GAP) && ((p % per) < (per >> (4 - int'(v))));
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_active <= 1'b0; m_loop <= 1'b0; m_beep <= 1'b0; m_done <= 1'b0;
      m_t <= 0; m_svol <= 2'd0;
    end else begin
      m_beep <= m_active && !stop && tone_on(m_t, m_svol);
      m_done <= 1'b0;
      if (!m_active) begin
        if (start && !stop) begin
          m_active <= 1'b1; m_t <= 0; m_loop <= loop; m_svol <= vol;
        end
      end else if (stop) begin
        m_active <= 1'b0;
      end else if (m_t == LEN - 1 && !m_loop) begin
        m_active <= 1'b0; m_done <= 1'b1;
      end else begin
        m_t <= (m_t + 1) % LEN;
        if ((m_t + 1) % NOTE == 0) m_svol <= vol;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    @(negedge sys_clk);
    chk("beep", int'(beep), int'(m_beep));
    chk("busy", int'(busy), int'(m_active));
    chk("note_idx", int'(note_idx), m_active ? m_t / NOTE : 0);
    chk("done", int'(done), int'(m_done));
  endtask

  task automatic run(input int n);
    repeat (n) cycle_check();
  endtask

  task automatic pulse(input bit s, input bit p);
    start = s; stop = p;
    cycle_check();
    start = 1'b0; stop = 1'b0;
  endtask

  typedef struct {
    bit         start, stop, loop;
    logic [1:0] vol;
    int         wait_n;
    bit         e_busy;
    int         e_note;
    bit         e_beep, e_done;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 1, 0, 2'd3,   10, 0, 0, 0, 0};  // start+stop in IDLE
    vt[1] = '{1, 0, 0, 2'd3,  299, 1, 0, 0, 0};
    vt[2] = '{1, 0, 0, 2'd3,  300, 1, 1, 0, 0};  // start while busy at clk 300
    vt[3] = '{0, 0, 0, 2'd3, 3599, 0, 0, 0, 1};  // done at 4200
    vt[4] = '{1, 0, 1, 2'd2, 4199, 1, 6, 0, 0};
    vt[5] = '{0, 0, 1, 2'd2,    0, 1, 0, 0, 0};  // loop wrap, no done
    vt[6] = '{0, 0, 1, 2'd2,  799, 1, 1, 0, 0};  // clk 5000
    vt[7] = '{0, 1, 1, 2'd2,    0, 0, 0, 0, 0};  // stop

    run(3);
    sys_rst = 1'b0;
    run(1000);

    for (int i = 0; i < 8; i++) begin
      loop = vt[i].loop; vol = vt[i].vol;
      pulse(vt[i].start, vt[i].stop);
      run(vt[i].wait_n);
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].e_busy));
      chk($sformatf("vec%0d note", i), int'(note_idx), vt[i].e_note);
      chk($sformatf("vec%0d beep", i), int'(beep), int'(vt[i].e_beep));
      chk($sformatf("vec%0d done", i), int'(done), int'(vt[i].e_done));
    end

    // High-time per DO period at low volumes.
    for (int v = 0; v < 2; v++) begin
      int highs;
      highs = 0;
      loop = 1'b0; vol = 2'(v);
      pulse(1'b1, 1'b0);
      for (int c = 0; c < 150; c++) begin
        cycle_check();
        highs += int'(beep);
      end
      chk($sformatf("DO highs vol%0d", v), highs, (v == 0) ? 9 : 18);
      pulse(1'b0, 1'b1);
      run(5);
    end

    // XI at vol 0 has zero duty: silent for the whole slot.
    begin
      int highs;
      highs = 0;
      vol = 2'd0;
      pulse(1'b1, 1'b0);
      run(3600);
      for (int c = 0; c < 600; c++) begin
        cycle_check();
        highs += int'(beep);
      end
      chk("XI highs vol0", highs, 0);
      chk("XI end done", int'(done), 1);
      run(5);
    end

    // Randomized control traffic.
    for (int c = 0; c < 12000; c++) begin
      start = ($urandom_range(199) == 0);
      stop  = ($urandom_range(1499) == 0);
      if ($urandom_range(99) == 0) loop = 1'($urandom_range(1));
      if ($urandom_range(49) == 0) vol = 2'($urandom_range(3));
      cycle_check();
    end
    start = 1'b0; stop = 1'b0;
    pulse(1'b0, 1'b1);
    run(5);

    // Asynchronous reset between edges in note 3.
    loop = 1'b0; vol = 2'd3;
    pulse(1'b1, 1'b0);
    run(1900);
    chk("pre-reset note", int'(note_idx), 3);
    @(posedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("async rst beep", int'(beep), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst note", int'(note_idx), 0);
    run(3);
    sys_rst = 1'b0;
    run(50);
    chk("post-reset busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
